ternary_neuron_seq: RTL

TERNARY_NEURON_SEQ -- requirements
Module: ternary_neuron_seq

---
 rtl/ternary_neuron_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ternary_neuron_seq.sv
// ============================================================================
//  Module      : ternary_neuron_seq
//  Description : Sequential ternary-weight neuron. A small weight RAM holds
//                one ternary code per input; a three-state FSM streams N_IN
//                signed activations through add/subtract/skip, then presents
//                an 8-bit saturated result on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ternary_neuron_seq #(
  parameter int N_IN  = 8,
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    cfg_we,
  input  logic [$clog2(N_IN)-1:0] cfg_addr,
  input  logic [1:0]              cfg_wdata,
  input  logic                    start,
  input  logic                    act_valid,
  input  logic [7:0]              act_data,
  output logic                    act_ready,
  output logic                    res_valid,
  output logic [7:0]              res_data,
  output logic                    res_sat,
  input  logic                    res_ready,
  output logic                    busy
);

  localparam int IDX_W = $clog2(N_IN);

  // Saturation bounds of the 8-bit signed result, expressed at accumulator width
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

  // Ternary weight encodings; the two remaining codes both mean zero
  localparam logic [1:0] W_POS = 2'b01;
  localparam logic [1:0] W_NEG = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                  state;
  logic [1:0]              weight [N_IN];
  logic signed [ACC_W-1:0] acc;
  logic [IDX_W-1:0]        idx;
  logic                    ready_q;

  logic [1:0]              cur_w;
  logic signed [ACC_W-1:0] act_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic                    accept;
  logic                    last_act;
  logic                    clip_hi;
  logic                    clip_lo;

  // Sign-extend the incoming activation to accumulator width
  assign act_ext = {{(ACC_W-8){act_data[7]}}, act_data};

  // Weight for the activation currently being offered
  assign cur_w = weight[idx];

  // Add, subtract or skip depending on the ternary weight; no multiplier
  always_comb begin
    acc_next = acc;
    case (cur_w)
      W_POS:   acc_next = acc + act_ext;
      W_NEG:   acc_next = acc - act_ext;
      default: acc_next = acc;
    endcase
  end

  // An activation is consumed only while ready is presented and ena is high
  assign accept   = ready_q && ena && act_valid;
  assign last_act = (idx == IDX_W'(N_IN - 1));
  assign clip_hi  = (acc_next > SAT_MAX);
  assign clip_lo  = (acc_next < SAT_MIN);

  // ena low must drop ready at once, so the registered flag is gated here
  assign act_ready = ready_q && ena;
  assign busy      = (state != IDLE);

  // FSM, weight store, accumulator and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      ready_q   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_sat   <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        weight[i] <= 2'b00;
      end
    end else if (ena) begin
      case (state)
        IDLE: begin
          // Write and start may coincide; the new weight is read later in ACCUM
          if (cfg_we) begin
            for (int i = 0; i < N_IN; i++) begin
              if (cfg_addr == IDX_W'(i)) begin
                weight[i] <= cfg_wdata;
              end
            end
          end
          if (start) begin
            acc     <= '0;
            idx     <= '0;
            ready_q <= 1'b1;
            state   <= ACCUM;
          end
        end

        ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            if (last_act) begin
              // Result is captured from the final sum so it is valid next cycle
              idx       <= '0;
              ready_q   <= 1'b0;
              res_valid <= 1'b1;
              res_sat   <= clip_hi || clip_lo;
              if (clip_hi) begin
                res_data <= 8'h7F;
              end else if (clip_lo) begin
                res_data <= 8'h80;
              end else begin
                res_data <= acc_next[7:0];
              end
              state <= OUTPUT;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          ready_q   <= 1'b0;
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
